// File: rtl/rns_compare_arbiter_9_8_7_pkg.sv
// Shared constants and types for the 7/8/9 residue compare arbiter.
package rns_compare_arbiter_9_8_7_pkg;

  localparam int unsigned MOD1  = 7;
  localparam int unsigned MOD2  = 8;
  localparam int unsigned MOD3  = 9;
  localparam int unsigned RANGE = 504;

  localparam int unsigned W1   = 3;
  localparam int unsigned W2   = 4;
  localparam int unsigned W3   = 4;
  localparam int unsigned WBIN = 9;

  localparam logic [WBIN-1:0] CONST_RST_DEF = 9'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_CMP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic residue_err(input logic [W1-1:0] a1,
                                       input logic [W2-1:0] a2,
                                       input logic [W3-1:0] a3);
    return (32'(a1) >= MOD1) || (32'(a2) >= MOD2) || (32'(a3) >= MOD3);
  endfunction

endpackage

// File: rtl/rns_compare_arbiter_9_8_7_reverse_converter.sv
// Combinational CRT reverse converter for moduli 7/8/9 (result range 0..503).
module reverse_converter_9_8_7
  import rns_compare_arbiter_9_8_7_pkg::*;
(
  input  logic [W1-1:0]   i_a1,
  input  logic [W2-1:0]   i_a2,
  input  logic [W3-1:0]   i_a3,
  output logic [WBIN-1:0] o_bin
);

  // CRT weights: Mi * (Mi^-1 mod mi) with M = 504 -> 288, 441, 280.
  logic [13:0] w_sum;

  assign w_sum = 14'(i_a1) * 14'd288 + 14'(i_a2) * 14'd441 + 14'(i_a3) * 14'd280;
  assign o_bin = WBIN'(w_sum % 14'd504);

endmodule

// File: rtl/rns_compare_arbiter_9_8_7.sv
// Two-requester round-robin front end sharing one RNS reverse converter,
// comparing each converted operand against a snapshotted 9-bit threshold.
//
// state | meaning
// IDLE  | waiting for a requester; ready offered to the granted one
// CONV  | latched residues go through the converter
// CMP   | converted value compared against the threshold snapshot
// RESP  | result held until the consumer takes it
module rns_compare_arbiter_9_8_7
  import rns_compare_arbiter_9_8_7_pkg::*;
#(
  parameter logic [WBIN-1:0] CONST_RST = CONST_RST_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            req0_valid_in,
  output logic            req0_ready_out,
  input  logic [W1-1:0]   req0_a1_in,
  input  logic [W2-1:0]   req0_a2_in,
  input  logic [W3-1:0]   req0_a3_in,
  input  logic            req1_valid_in,
  output logic            req1_ready_out,
  input  logic [W1-1:0]   req1_a1_in,
  input  logic [W2-1:0]   req1_a2_in,
  input  logic [W3-1:0]   req1_a3_in,
  input  logic            cfg_we_in,
  input  logic [WBIN-1:0] cfg_const_in,
  output logic            res_valid_out,
  input  logic            res_ready_in,
  output logic            res_id_out,
  output logic            res_le_out,
  output logic            res_eq_out,
  output logic            res_gr_out,
  output logic            res_err_out,
  output logic            busy_out
);

  state_t          r_state;
  logic            r_last;
  logic [WBIN-1:0] r_thr;
  logic [WBIN-1:0] r_snap;
  logic [W1-1:0]   r_a1;
  logic [W2-1:0]   r_a2;
  logic [W3-1:0]   r_a3;
  logic            r_id;
  logic [WBIN-1:0] r_bin;
  logic            r_res_valid;
  logic            r_res_id;
  logic            r_le;
  logic            r_eq;
  logic            r_gr;
  logic            r_err;

  logic            w_idle;
  logic            w_gnt;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_acc;
  logic [WBIN-1:0] w_conv;
  logic            w_err;

  // Ready is withheld during reset so no operand is accepted on a reset edge.
  assign w_idle = (r_state == ST_IDLE) && !rst_in;

  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid_in && req1_valid_in) w_gnt = ~r_last;
    else if (req1_valid_in)             w_gnt = 1'b1;
  end

  assign w_rdy0 = w_idle && req0_valid_in && !w_gnt;
  assign w_rdy1 = w_idle && req1_valid_in && w_gnt;
  assign w_acc  = w_rdy0 || w_rdy1;

  reverse_converter_9_8_7 u_conv (
    .i_a1  (r_a1),
    .i_a2  (r_a2),
    .i_a3  (r_a3),
    .o_bin (w_conv)
  );

  assign w_err = residue_err(r_a1, r_a2, r_a3);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_thr       <= CONST_RST;
      r_snap      <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_a3        <= '0;
      r_id        <= 1'b0;
      r_bin       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_le        <= 1'b0;
      r_eq        <= 1'b0;
      r_gr        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (cfg_we_in) r_thr <= cfg_const_in;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_a1    <= w_gnt ? req1_a1_in : req0_a1_in;
            r_a2    <= w_gnt ? req1_a2_in : req0_a2_in;
            r_a3    <= w_gnt ? req1_a3_in : req0_a3_in;
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_snap  <= r_thr;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bin   <= w_conv;
          r_state <= ST_CMP;
        end
        ST_CMP: begin
          r_res_valid <= 1'b1;
          r_res_id    <= r_id;
          r_err       <= w_err;
          r_le        <= !w_err && (r_bin <  r_snap);
          r_eq        <= !w_err && (r_bin == r_snap);
          r_gr        <= !w_err && (r_bin >  r_snap);
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready_in) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready_out = w_rdy0;
  assign req1_ready_out = w_rdy1;
  assign res_valid_out  = r_res_valid;
  assign res_id_out     = r_res_id;
  assign res_le_out     = r_le;
  assign res_eq_out     = r_eq;
  assign res_gr_out     = r_gr;
  assign res_err_out    = r_err;
  assign busy_out       = (r_state != ST_IDLE);

endmodule
